vend_led_ctrl: RTL and testbench
================================

# vend_led_ctrl

Registered, parametrised indicator-LED controller for the vending machine. It decodes the 3-bit FSM status into power, money, per-channel dispense and refund LEDs. Unlike a pure status decoder, it adds blinking modes, minimum-on hold timers for dispense and refund, per-product-channel dispense LEDs and a lamp test. It sits between the main vending FSM and the board LED pins.

## Interface
- NUM_CH, 4, number of product channels (one get LED each), 1..16
- BLINK_DIV, 25_000_000, clock cycles per blink half-period, ≥2
- HOLD_CYC, 50_000_000, minimum cycles get/back LED stays lit after event, ≥1
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- status  in  3  vending FSM state code
- ch_sel  in  max(1,$clog2(NUM_CH))  product channel being dispensed; sampled on entry to DISPENSE
- lamp_test  in  1  forces every LED output on while high
- power_led  out  1  power indicator
- money_led  out  1  credit indicator
- get_led  out  NUM_CH  one-hot dispense indicator
- back_led  out  1  refund indicator
- ch_err  out  1  latched ch_sel was ≥ NUM_CH

## Operation
- Status codes: 0 OFF, 1 IDLE, 2 COIN_A, 3 COIN_B, 4 CREDIT_OK, 5 DISPENSE, 6 REFUND, 7 FAULT.
- Decode:
  - OFF: all LEDs 0.
  - IDLE: power on.
  - COIN_A/COIN_B: power and money steady on.
  - CREDIT_OK: power on, money blinking.
  - DISPENSE: power on, get_led[ch] on.
  - REFUND: power on, back on.
  - FAULT: power blinking, all others 0.
- Blink generator:
  - Counter 0..BLINK_DIV-1 with a phase bit.
  - Phase toggles when the counter wraps.
  - On entry to CREDIT_OK or FAULT (status differs from the previous cycle), counter clears to 0 and phase is set to 1, so the first half-period is always on.
- Get hold:
  - On entry to DISPENSE, latch ch_sel and load the get timer with HOLD_CYC.
  - get_led[ch] stays on while status==DISPENSE or the timer is non-zero; the timer decrements to 0 only outside DISPENSE.
- Back hold: identical mechanism on entry to REFUND.
- Mutual exclusion:
  - Entering REFUND clears the get timer and get_led immediately.
  - Entering DISPENSE clears the back timer immediately.
- Re-entry to DISPENSE while the get hold is active: relatch ch_sel and reload the timer; only the new channel is lit.
- ch_sel ≥ NUM_CH at latch: no get_led bit set, ch_err=1 until the next DISPENSE entry or OFF.
- Status OFF clears both timers, blink state and ch_err at once.
- lamp_test: power, money, back and all get_led forced to 1. Internal timers and blink state keep running unaffected.

## Timing
- All outputs registered; reset value of every output is 0. Internal state resets to: timers 0, blink counter 0, phase 1, previous status OFF.
- Latency: status change → LED change in exactly 1 clk.
- Entry detection compares status against a registered copy, so entry is seen on the first cycle of the new code.
- Hold timer: LED stays on for exactly HOLD_CYC cycles after the first cycle status is no longer DISPENSE/REFUND (unless a clear rule fires).
- Blink period is 2×BLINK_DIV cycles, 50 % duty.
- Reset assertion mid-hold or mid-blink: outputs go to 0 asynchronously. Deassertion acts as if the previous status was OFF.
- lamp_test takes effect with 1-cycle latency, same as status.

## Structure
- Shared package vend_pkg holds:
  - status code localparams (ST_OFF..ST_FAULT), shared with the main FSM;
  - the 3-bit status typedef.
- One sub-module vend_hold_timer (load, clear, run, busy; width $clog2(HOLD_CYC+1)), instantiated twice for get and back.
- Blink generator and decode stay inline.

## Test plan
Bench parameters: NUM_CH=4, BLINK_DIV=4, HOLD_CYC=8.
1. Reset, status=1 → all outputs 0 during reset; power_led=1 on the 1st clk after release, others 0.
2. status=4 for 20 cycles → money_led pattern 1111 0000 1111 0000…, starting 1 cycle after entry; power steady 1.
3. status=5 with ch_sel=2 for 3 cycles, then status=1 → get_led=4'b0100 for 3+8 cycles, then 0.
4. DISPENSE ch 2, return to IDLE, then after 3 cycles DISPENSE ch 1 → get_led switches to 4'b0010, never 4'b0110. Then REFUND → get_led=0 and back_led=1 on the same edge.
5. status=5 with ch_sel=5 → get_led=0, ch_err=1; status=0 → ch_err=0 next cycle.
6. Mid-hold (back timer at 4), assert rst_n=0 → all outputs 0 immediately. Release with status=1 → only power_led=1.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: status codes driven by the main FSM and
// decoded by the LED controller.
package vend_pkg;

  typedef logic [2:0] status_t;

  localparam status_t ST_OFF       = 3'd0;
  localparam status_t ST_IDLE      = 3'd1;
  localparam status_t ST_COIN_A    = 3'd2;
  localparam status_t ST_COIN_B    = 3'd3;
  localparam status_t ST_CREDIT_OK = 3'd4;
  localparam status_t ST_DISPENSE  = 3'd5;
  localparam status_t ST_REFUND    = 3'd6;
  localparam status_t ST_FAULT     = 3'd7;

endpackage

// File: rtl/vend_hold_timer.sv
// Minimum-on hold timer: loads HOLD_CYC, counts down while run is high,
// and reports busy while the count is non-zero.
module vend_hold_timer #(
  parameter int unsigned HOLD_CYC = 50_000_000,
  localparam int unsigned W = $clog2(HOLD_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  input  logic run,
  output logic busy
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= W'(HOLD_CYC);
    end else if (run && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/vend_led_ctrl.sv
// Indicator-LED controller: decodes vending FSM status into registered LED
// outputs with blinking, dispense/refund hold timers and a lamp test.
module vend_led_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned HOLD_CYC  = 50_000_000,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned BW   = $clog2(BLINK_DIV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        status,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              lamp_test,
  output logic              power_led,
  output logic              money_led,
  output logic [NUM_CH-1:0] get_led,
  output logic              back_led,
  output logic              ch_err
);

  status_t         prev_q;
  logic [BW-1:0]   cnt_q, cnt_eff, cnt_d;
  logic            phase_q, ph_eff, phase_d;
  logic [CH_W-1:0] ch_q, ch_eff;
  logic            entry, blink_entry, disp_entry, refund_entry, is_off;
  logic            get_busy, back_busy, get_on, back_on, hold_ok;
  logic [NUM_CH-1:0] get_vec;
  logic            power_d, money_d, back_d;
  logic [NUM_CH-1:0] get_d;

  assign is_off       = (status == ST_OFF);
  assign entry        = (status != prev_q);
  assign blink_entry  = entry && (status == ST_CREDIT_OK || status == ST_FAULT);
  assign disp_entry   = entry && (status == ST_DISPENSE);
  assign refund_entry = entry && (status == ST_REFUND);

  // Entry cycle acts as count 0 of an "on" half-period so the first one is full length.
  assign cnt_eff = blink_entry ? '0 : cnt_q;
  assign ph_eff  = blink_entry ? 1'b1 : phase_q;
  assign ch_eff  = disp_entry ? ch_sel : ch_q;

  always_comb begin
    cnt_d   = cnt_eff + 1'b1;
    phase_d = ph_eff;
    if (is_off) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_eff == BW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~ph_eff;
    end
  end

  vend_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_get_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (disp_entry),
    .clear (is_off || refund_entry),
    .run   (status != ST_DISPENSE),
    .busy  (get_busy)
  );

  vend_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_back_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (refund_entry),
    .clear (is_off || disp_entry),
    .run   (status != ST_REFUND),
    .busy  (back_busy)
  );

  assign get_on  = (status == ST_DISPENSE) || (get_busy && !refund_entry);
  assign back_on = (status == ST_REFUND) || (back_busy && !disp_entry);
  assign hold_ok = !is_off && (status != ST_FAULT);

  always_comb begin
    get_vec = '0;
    if (get_on && (32'(ch_eff) < NUM_CH)) get_vec[ch_eff] = 1'b1;
  end

  always_comb begin
    power_d = 1'b0;
    money_d = 1'b0;
    case (status)
      ST_IDLE, ST_DISPENSE, ST_REFUND: power_d = 1'b1;
      ST_COIN_A, ST_COIN_B: begin
        power_d = 1'b1;
        money_d = 1'b1;
      end
      ST_CREDIT_OK: begin
        power_d = 1'b1;
        money_d = ph_eff;
      end
      ST_FAULT: power_d = ph_eff;
      default: ;
    endcase
    get_d  = hold_ok ? get_vec : '0;
    back_d = hold_ok && back_on;
    if (lamp_test) begin
      power_d = 1'b1;
      money_d = 1'b1;
      back_d  = 1'b1;
      get_d   = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= ST_OFF;
      cnt_q     <= '0;
      phase_q   <= 1'b1;
      ch_q      <= '0;
      ch_err    <= 1'b0;
      power_led <= 1'b0;
      money_led <= 1'b0;
      get_led   <= '0;
      back_led  <= 1'b0;
    end else begin
      prev_q    <= status;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      ch_q      <= ch_eff;
      if (is_off) begin
        ch_err <= 1'b0;
      end else if (disp_entry) begin
        ch_err <= (32'(ch_sel) >= NUM_CH);
      end
      power_led <= power_d;
      money_led <= money_d;
      get_led   <= get_d;
      back_led  <= back_d;
    end
  end

endmodule

// File: tb/tb_vend_led_ctrl.sv
// Directed bench for vend_led_ctrl: expected LED states are queued with each
// stimulus step and compared one clock later. A 3-channel copy covers ch_err.
module tb_vend_led_ctrl;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] status;
  logic [1:0] ch_sel;
  logic       lamp_test;
  logic       power_led, money_led, back_led, ch_err;
  logic [3:0] get_led;
  logic       power3, money3, back3, ch_err3;
  logic [2:0] get3;

  typedef struct packed {
    logic       p;
    logic       m;
    logic [3:0] g;
    logic       b;
    logic       e;
    logic       chk3;
    logic [2:0] g3;
    logic       e3;
  } exp_t;

  exp_t sb_q[$];
  exp_t ex;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vend_led_ctrl #(.NUM_CH(4), .BLINK_DIV(4), .HOLD_CYC(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .status    (status),
    .ch_sel    (ch_sel),
    .lamp_test (lamp_test),
    .power_led (power_led),
    .money_led (money_led),
    .get_led   (get_led),
    .back_led  (back_led),
    .ch_err    (ch_err)
  );

  // With 4 channels a 2-bit ch_sel cannot go out of range; this copy can.
  vend_led_ctrl #(.NUM_CH(3), .BLINK_DIV(4), .HOLD_CYC(8)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .status    (status),
    .ch_sel    (ch_sel),
    .lamp_test (lamp_test),
    .power_led (power3),
    .money_led (money3),
    .get_led   (get3),
    .back_led  (back3),
    .ch_err    (ch_err3)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic m, input logic [3:0] g,
                              input logic b, input logic e);
    exp_t r;
    r      = '0;
    r.p    = p;
    r.m    = m;
    r.g    = g;
    r.b    = b;
    r.e    = e;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_power"}, 8'(power_led), 8'd0);
    check({tag, "_money"}, 8'(money_led), 8'd0);
    check({tag, "_get"},   8'(get_led),   8'd0);
    check({tag, "_back"},  8'(back_led),  8'd0);
    check({tag, "_err"},   8'(ch_err),    8'd0);
    check({tag, "_get3"},  8'(get3),      8'd0);
    check({tag, "_err3"},  8'(ch_err3),   8'd0);
  endtask

  task automatic step(input logic [2:0] st, input logic [1:0] ch, input logic lt,
                      input exp_t e, input string tag);
    exp_t c;
    status    = st;
    ch_sel    = ch;
    lamp_test = lt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    c = sb_q.pop_front();
    check({tag, "_power"}, 8'(power_led), 8'(c.p));
    check({tag, "_money"}, 8'(money_led), 8'(c.m));
    check({tag, "_get"},   8'(get_led),   8'(c.g));
    check({tag, "_back"},  8'(back_led),  8'(c.b));
    check({tag, "_err"},   8'(ch_err),    8'(c.e));
    if (c.chk3) begin
      check({tag, "_get3"}, 8'(get3),    8'(c.g3));
      check({tag, "_err3"}, 8'(ch_err3), 8'(c.e3));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    status    = ST_IDLE;
    ch_sel    = 2'd0;
    lamp_test = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    rst_n = 1'b1;
    step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0000, 0, 0), "idle_first");
    step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0000, 0, 0), "idle");
    step(ST_COIN_A, 2'd0, 1'b0, mk(1, 1, 4'b0000, 0, 0), "coin_a");

    for (int i = 0; i < 20; i++)
      step(ST_CREDIT_OK, 2'd0, 1'b0, mk(1, (i % 8) < 4, 4'b0000, 0, 0), "credit_blink");
    for (int i = 0; i < 10; i++)
      step(ST_FAULT, 2'd0, 1'b0, mk((i % 8) < 4, 0, 4'b0000, 0, 0), "fault_blink");
    step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0000, 0, 0), "idle_after_fault");

    // Dispense hold: lit for 3 DISPENSE cycles plus HOLD_CYC cycles after.
    for (int i = 0; i < 3; i++)
      step(ST_DISPENSE, 2'd2, 1'b0, mk(1, 0, 4'b0100, 0, 0), "disp_ch2");
    for (int i = 0; i < 8; i++)
      step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0100, 0, 0), "get_hold");
    step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0000, 0, 0), "get_hold_end");

    // Re-entry switches channel; refund clears the get hold on the same edge.
    for (int i = 0; i < 2; i++)
      step(ST_DISPENSE, 2'd2, 1'b0, mk(1, 0, 4'b0100, 0, 0), "redisp_ch2");
    for (int i = 0; i < 3; i++)
      step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0100, 0, 0), "regap_hold");
    for (int i = 0; i < 2; i++)
      step(ST_DISPENSE, 2'd1, 1'b0, mk(1, 0, 4'b0010, 0, 0), "redisp_ch1");
    for (int i = 0; i < 2; i++)
      step(ST_REFUND, 2'd1, 1'b0, mk(1, 0, 4'b0000, 1, 0), "refund");
    for (int i = 0; i < 4; i++)
      step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0000, 1, 0), "back_hold");

    // Back timer now holds 4: asynchronous reset mid-hold.
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0000, 0, 0), "post_rst");
    step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0000, 0, 0), "post_rst2");

    step(ST_IDLE, 2'd0, 1'b1, mk(1, 1, 4'b1111, 1, 0), "lamp_on");
    step(ST_IDLE, 2'd0, 1'b0, mk(1, 0, 4'b0000, 0, 0), "lamp_off");

    // Channel 3 is valid for 4 channels and out of range for 3.
    ex = mk(1, 0, 4'b1000, 0, 0);
    ex.chk3 = 1'b1;
    ex.g3   = 3'b000;
    ex.e3   = 1'b1;
    step(ST_DISPENSE, 2'd3, 1'b0, ex, "disp_ch3");
    step(ST_DISPENSE, 2'd3, 1'b0, ex, "disp_ch3_b");
    step(ST_IDLE, 2'd0, 1'b0, ex, "ch3_hold");
    ex = mk(1, 0, 4'b0010, 0, 0);
    ex.chk3 = 1'b1;
    ex.g3   = 3'b010;
    ex.e3   = 1'b0;
    step(ST_DISPENSE, 2'd1, 1'b0, ex, "disp_valid_clears_err");
    step(ST_DISPENSE, 2'd3, 1'b0, ex, "disp_hold_ch1");
    ex = mk(1, 0, 4'b0010, 0, 0);
    ex.chk3 = 1'b1;
    ex.g3   = 3'b010;
    step(ST_IDLE, 2'd3, 1'b0, ex, "idle_hold_ch1");
    step(ST_IDLE, 2'd3, 1'b0, ex, "idle_hold_ch1_b");
    step(ST_DISPENSE, 2'd3, 1'b0, mk(1, 0, 4'b1000, 0, 0), "disp_ch3_again");
    ex = mk(0, 0, 4'b0000, 0, 0);
    ex.chk3 = 1'b1;
    step(ST_OFF, 2'd0, 1'b0, ex, "off_clears");
    step(ST_IDLE, 2'd0, 1'b0, ex ^ exp_t'(mk(1, 0, 4'b0000, 0, 0)), "idle_after_off");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
